bus_cycle_ctrl: RTL

Machine-cycle sequencer for the 8085 external bus. It sits between the instruction decoder and the pins. It takes a cycle request (opcode fetch, memory read/write, I/O read/write) with address and write data, then steps through T1/T2/TW/T3/T4. Along the way it generates ALE, RDn, WRn, IOMn, S1, S0 and the multiplexed AD7..AD0 drive/enable, and returns captured read data. It also handles READY wait states and HOLD/HLDA bus release.

---
 rtl/bus_cycle_ctrl_if.sv | 44 ++++
 rtl/bus_cycle_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_cycle_ctrl_if
// Description : Decoder/pin-side bundle for the 8085 machine-cycle sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_cycle_ctrl_if;
    logic        cyc_req;
    logic [2:0]  cyc_type;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  ad_in;
    logic        ready;
    logic        hold;
    logic [7:0]  haddress;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic        ctl_oe;
    logic        ALE;
    logic        RDn;
    logic        WRn;
    logic        IOMn;
    logic        S0;
    logic        S1;
    logic        hlda;
    logic        cyc_ack;
    logic        cyc_done;
    logic        cyc_err;
    logic [7:0]  rdata;
    logic [2:0]  tstate;

    modport master (
        output cyc_req, cyc_type, addr, wdata, ad_in, ready, hold,
        input  haddress, ad_out, ad_oe, ctl_oe, ALE, RDn, WRn, IOMn, S0, S1,
        input  hlda, cyc_ack, cyc_done, cyc_err, rdata, tstate
    );

    modport slave (
        input  cyc_req, cyc_type, addr, wdata, ad_in, ready, hold,
        output haddress, ad_out, ad_oe, ctl_oe, ALE, RDn, WRn, IOMn, S0, S1,
        output hlda, cyc_ack, cyc_done, cyc_err, rdata, tstate
    );
endinterface
`default_nettype wire

// File: rtl/bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bus_cycle_ctrl
// Description : 8085 T-state sequencer driving ALE/RDn/WRn/status, READY waits
//               and HOLD/HLDA bus release. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_cycle_ctrl (
    input  wire logic      phi1,
    input  wire logic      rst,
    bus_cycle_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_TI = 3'd0,
        S_T1 = 3'd1,
        S_T2 = 3'd2,
        S_TW = 3'd3,
        S_T3 = 3'd4,
        S_T4 = 3'd5,
        S_TH = 3'd6
    } state_t;

    localparam logic [2:0] C_TYPE_FETCH = 3'd0;
    localparam logic [2:0] C_TYPE_MWR   = 3'd2;
    localparam logic [2:0] C_TYPE_IOWR  = 3'd4;

    state_t      r_state;
    logic [2:0]  r_type;
    logic [7:0]  r_wdata;
    logic [7:0]  r_haddress;
    logic [7:0]  r_ad_out;
    logic        r_ad_oe;
    logic        r_ctl_oe;
    logic        r_ale;
    logic        r_rdn;
    logic        r_wrn;
    logic        r_iomn;
    logic        r_s0;
    logic        r_s1;
    logic        r_hlda;
    logic        r_cyc_ack;
    logic        r_cyc_done;
    logic        r_cyc_err;
    logic [7:0]  r_rdata;

    logic        w_req_legal;
    logic        w_req_s1;
    logic        w_req_s0;
    logic        w_req_iomn;
    logic        w_is_wr;
    logic        w_is_fetch;

    // Status decode for the incoming request; it becomes visible in T1.
    always_comb begin
        w_req_legal = (bus.cyc_type <= C_TYPE_IOWR);
        w_req_s1    = (bus.cyc_type == 3'd0) || (bus.cyc_type == 3'd1) || (bus.cyc_type == 3'd3);
        w_req_s0    = (bus.cyc_type == 3'd0) || (bus.cyc_type == 3'd2) || (bus.cyc_type == 3'd4);
        w_req_iomn  = (bus.cyc_type == 3'd3) || (bus.cyc_type == 3'd4);
        w_is_wr     = (r_type == C_TYPE_MWR) || (r_type == C_TYPE_IOWR);
        w_is_fetch  = (r_type == C_TYPE_FETCH);
    end

    always_ff @(posedge phi1) begin
        if (rst) begin
            r_state    <= S_TI;
            r_type     <= 3'd0;
            r_wdata    <= 8'd0;
            r_haddress <= 8'd0;
            r_ad_out   <= 8'd0;
            r_ad_oe    <= 1'b0;
            r_ctl_oe   <= 1'b1;
            r_ale      <= 1'b0;
            r_rdn      <= 1'b1;
            r_wrn      <= 1'b1;
            r_iomn     <= 1'b0;
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
            r_hlda     <= 1'b0;
            r_cyc_ack  <= 1'b0;
            r_cyc_done <= 1'b0;
            r_cyc_err  <= 1'b0;
            r_rdata    <= 8'd0;
        end else begin
            r_cyc_ack  <= 1'b0;
            r_cyc_done <= 1'b0;
            r_cyc_err  <= 1'b0;
            case (r_state)
                S_TI: begin
                    if (bus.hold) begin
                        r_state  <= S_TH;
                        r_hlda   <= 1'b1;
                        r_ctl_oe <= 1'b0;
                        r_ad_oe  <= 1'b0;
                        r_ale    <= 1'b0;
                    end else if (bus.cyc_req && w_req_legal) begin
                        r_state    <= S_T1;
                        r_type     <= bus.cyc_type;
                        r_wdata    <= bus.wdata;
                        r_haddress <= bus.addr[15:8];
                        r_ad_out   <= bus.addr[7:0];
                        r_ad_oe    <= 1'b1;
                        r_ale      <= 1'b1;
                        r_s1       <= w_req_s1;
                        r_s0       <= w_req_s0;
                        r_iomn     <= w_req_iomn;
                        r_cyc_ack  <= 1'b1;
                    end else if (bus.cyc_req) begin
                        r_cyc_err <= 1'b1;
                    end
                end
                S_T1: begin
                    r_state <= S_T2;
                    r_ale   <= 1'b0;
                    if (w_is_wr) begin
                        r_wrn    <= 1'b0;
                        r_ad_oe  <= 1'b1;
                        r_ad_out <= r_wdata;
                    end else begin
                        r_rdn   <= 1'b0;
                        r_ad_oe <= 1'b0;
                    end
                end
                S_T2, S_TW: begin
                    r_state <= bus.ready ? S_T3 : S_TW;
                end
                S_T3: begin
                    if (!w_is_wr) begin
                        r_rdata <= bus.ad_in;
                    end
                    if (w_is_fetch) begin
                        r_state <= S_T4;
                        r_rdn   <= 1'b1;
                        r_ad_oe <= 1'b0;
                    end else begin
                        r_state    <= S_TI;
                        r_rdn      <= 1'b1;
                        r_wrn      <= 1'b1;
                        r_ad_oe    <= 1'b0;
                        r_s1       <= 1'b0;
                        r_s0       <= 1'b0;
                        r_iomn     <= 1'b0;
                        r_cyc_done <= 1'b1;
                    end
                end
                S_T4: begin
                    r_state    <= S_TI;
                    r_rdn      <= 1'b1;
                    r_wrn      <= 1'b1;
                    r_ad_oe    <= 1'b0;
                    r_s1       <= 1'b0;
                    r_s0       <= 1'b0;
                    r_iomn     <= 1'b0;
                    r_cyc_done <= 1'b1;
                end
                S_TH: begin
                    if (!bus.hold) begin
                        r_state  <= S_TI;
                        r_hlda   <= 1'b0;
                        r_ctl_oe <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_TI;
                end
            endcase
        end
    end

    assign bus.haddress = r_haddress;
    assign bus.ad_out   = r_ad_out;
    assign bus.ad_oe    = r_ad_oe;
    assign bus.ctl_oe   = r_ctl_oe;
    assign bus.ALE      = r_ale;
    assign bus.RDn      = r_rdn;
    assign bus.WRn      = r_wrn;
    assign bus.IOMn     = r_iomn;
    assign bus.S0       = r_s0;
    assign bus.S1       = r_s1;
    assign bus.hlda     = r_hlda;
    assign bus.cyc_ack  = r_cyc_ack;
    assign bus.cyc_done = r_cyc_done;
    assign bus.cyc_err  = r_cyc_err;
    assign bus.rdata    = r_rdata;
    assign bus.tstate   = r_state;

endmodule
`default_nettype wire
